conv2x2_mac_engine: RTL and testbench
=====================================

Name: conv2x2_mac_engine

Overview:
- Sequential multiply-accumulate stage between the SPI-loaded weight/data registers (upstream) and the 18-bit convolution readout stage (downstream).
- On `start`, it snapshots a 4x4 image of 8-bit pixels and a 2x2 kernel of 8-bit weights.
- It computes the 9 valid stride-1 2x2 convolution outputs, using one product per clock.
- It presents each 18-bit result to the readout stage over a valid/ready handshake.

Parameters:
- PIX_W, 8, width of each unsigned pixel and each unsigned weight.
- IMG_DIM, 4, image is IMG_DIM x IMG_DIM pixels.
- K_DIM, 2, kernel is K_DIM x K_DIM weights.
- ACC_W, 18, accumulator/result width. Must be at least 2*PIX_W + clog2(K_DIM*K_DIM).
- Only the defaults are required to be verified.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a run; sampled only in IDLE.
- data_in, input, IMG_DIM*IMG_DIM*PIX_W (128), pixel(r,c) = byte r*IMG_DIM+c; byte i = bits [8i+7:8i].
- weights_in, input, K_DIM*K_DIM*PIX_W (32), weight(kr,kc) = byte kr*K_DIM+kc.
- busy, output, 1, high while a run is in progress.
- out_valid, output, 1, out_data/out_index hold a result.
- out_ready, input, 1, downstream accepts a result when high together with out_valid.
- out_data, output, ACC_W, convolution result.
- out_index, output, 4, result index = r*(IMG_DIM-K_DIM+1)+c, range 0..8.
- done, output, 1, one-cycle pulse after the last result is accepted.

Behaviour:
- Arithmetic
  - Everything is unsigned.
  - out(r,c) = sum over kr,kc of weight(kr,kc)*pixel(r+kr,c+kc), for r,c in 0..2.
  - No overflow is possible at the defaults (maximum 4*255*255 = 260100).
- Reset: rst at a clock edge forces, in the next cycle:
  - state IDLE;
  - busy, out_valid and done = 0;
  - out_data, out_index and the internal accumulator/counters = 0.
  - This applies at any point mid-run; the run is abandoned and no partial result is emitted.
- FSM states: IDLE, MAC, HOLD.
- IDLE
  - On an edge with start=1: copy data_in and weights_in into internal snapshot registers, clear the accumulator, set window=0, set tap=0, go to MAC, busy<=1.
  - Later changes on data_in/weights_in do not affect the run.
- MAC
  - Each edge adds weight(tap)*pixel(window origin + tap offset) to the accumulator and increments tap. Taps are in row-major order: (0,0), (0,1), (1,0), (1,1).
  - On the 4th tap edge: out_data<=final sum, out_index<=window, out_valid<=1, go to HOLD.
- HOLD
  - out_data and out_index are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid<=0.
    - If window<8: window+1, clear accumulator, tap=0, go to MAC.
    - If window=8: go to IDLE, busy<=0, done<=1 for exactly one cycle.
- Windows advance row-major, with column wrap at c=2 to the next row.
- Latency
  - Let E0 be the edge that samples start.
  - out_valid first rises after E4.
  - With out_ready held high, result n transfers at edge E(5n+5).
  - The last transfer is at E45; done is high and busy low in the cycle after E45.
  - Throughput is one result per 5 clocks.
- Start while busy (including the final-transfer edge) is ignored.
- Start in the cycle done is high is accepted: state is already IDLE.
- Simultaneous rst and start: rst wins.

Test Plan:
1. All pixels 0x01, all weights 0x01, start, out_ready=1 -> nine results of 4 with indices 0..8; out_valid rises after E4; done pulses one cycle after E45; busy falls with it.
2. All pixels 0xFF, all weights 0xFF -> every result = 260100 (0x3F804); no truncation.
3. Pixel i = i, weights bytes {1,0,0,0} -> 0,1,2,4,5,6,8,9,10. Weights {0,0,0,1} -> 5,6,7,9,10,11,13,14,15. Weights {1,2,3,4} -> first result 34.
4. Backpressure: out_ready=0 for 10 cycles while index 3 is valid -> out_valid stays 1, out_data/out_index stable, then index 4 follows with no skip or duplicate.
5. Start pulsed mid-run and data_in/weights_in changed after E0 -> results identical to test 3; no restart.
6. rst asserted while index 4 is pending -> next cycle all outputs 0, IDLE; a new start yields the full 9-result sequence from index 0.

Source files
------------

// File: rtl/conv2x2_mac_engine.sv
// Sequential 2x2 convolution over a 4x4 unsigned image, one product per clock.
// Each window result is presented on a valid/ready port; done pulses after the last transfer.
module conv2x2_mac_engine #(
  parameter int PIX_W   = 8,
  parameter int IMG_DIM = 4,
  parameter int K_DIM   = 2,
  parameter int ACC_W   = 18
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [IMG_DIM*IMG_DIM*PIX_W-1:0] data_in,
  input  logic [K_DIM*K_DIM*PIX_W-1:0]     weights_in,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_data,
  output logic [3:0]                       out_index,
  output logic                             done
);

  localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
  localparam int RC_W    = $clog2(IMG_DIM);
  localparam int KC_W    = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int PIDX_W  = $clog2(IMG_DIM * IMG_DIM);
  localparam int TI_W    = (K_DIM > 1) ? $clog2(K_DIM * K_DIM) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic [IMG_DIM*IMG_DIM*PIX_W-1:0] r_data;
  logic [K_DIM*K_DIM*PIX_W-1:0]     r_wts;
  logic [ACC_W-1:0]                 r_acc;
  logic [RC_W-1:0]                  r_row;
  logic [RC_W-1:0]                  r_col;
  logic [KC_W-1:0]                  r_kr;
  logic [KC_W-1:0]                  r_kc;
  logic                             r_busy;
  logic                             r_out_valid;
  logic [ACC_W-1:0]                 r_out_data;
  logic [3:0]                       r_out_index;
  logic                             r_done;

  logic [RC_W-1:0]    w_pix_row;
  logic [RC_W-1:0]    w_pix_col;
  logic [PIDX_W-1:0]  w_pix_idx;
  logic [TI_W-1:0]    w_tap_idx;
  logic [PIX_W-1:0]   w_pix;
  logic [PIX_W-1:0]   w_wt;
  logic [2*PIX_W-1:0] w_prod;
  logic [ACC_W-1:0]   w_sum;
  logic [3:0]         w_win_idx;
  logic               w_last_tap;
  logic               w_last_col;
  logic               w_last_win;

  // Tap (kr,kc) of the current window selects one pixel/weight pair per cycle.
  assign w_pix_row  = r_row + RC_W'(r_kr);
  assign w_pix_col  = r_col + RC_W'(r_kc);
  assign w_pix_idx  = PIDX_W'(w_pix_row) * PIDX_W'(IMG_DIM) + PIDX_W'(w_pix_col);
  assign w_tap_idx  = TI_W'(r_kr) * TI_W'(K_DIM) + TI_W'(r_kc);
  assign w_pix      = r_data[w_pix_idx*PIX_W +: PIX_W];
  assign w_wt       = r_wts[w_tap_idx*PIX_W +: PIX_W];
  assign w_prod     = w_pix * w_wt;
  assign w_sum      = r_acc + ACC_W'(w_prod);
  assign w_win_idx  = 4'(r_row) * 4'(OUT_DIM) + 4'(r_col);
  assign w_last_tap = (r_kr == KC_W'(K_DIM - 1)) && (r_kc == KC_W'(K_DIM - 1));
  assign w_last_col = (r_col == RC_W'(OUT_DIM - 1));
  assign w_last_win = (r_row == RC_W'(OUT_DIM - 1)) && w_last_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_MAC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MAC: begin
        if (w_last_tap) begin
          w_next = S_HOLD;
        end else begin
          w_next = S_MAC;
        end
      end
      S_HOLD: begin
        if (out_ready && w_last_win) begin
          w_next = S_IDLE;
        end else if (out_ready) begin
          w_next = S_MAC;
        end else begin
          w_next = S_HOLD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_wts       <= '0;
      r_acc       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= 4'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_data <= data_in;
            r_wts  <= weights_in;
            r_acc  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_kr   <= '0;
            r_kc   <= '0;
            r_busy <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (r_kc == KC_W'(K_DIM - 1)) begin
            r_kc <= '0;
            r_kr <= r_kr + KC_W'(1);
          end else begin
            r_kc <= r_kc + KC_W'(1);
          end
          if (w_last_tap) begin
            r_out_data  <= w_sum;
            r_out_index <= w_win_idx;
            r_out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          // Result stays frozen until the readout stage takes it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_win) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_acc <= '0;
              r_kr  <= '0;
              r_kc  <= '0;
              if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + RC_W'(1);
              end else begin
                r_col <= r_col + RC_W'(1);
              end
            end
          end
        end
        default: begin
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign done      = r_done;

endmodule

// File: tb/tb_conv2x2_mac_engine.sv
// Scoreboard bench for conv2x2_mac_engine: expected results are queued at start and
// compared against each accepted transfer, plus latency, backpressure and reset scenarios.
module tb_conv2x2_mac_engine;

  typedef struct {
    logic [17:0] d;
    logic [3:0]  i;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] data_in;
  logic [31:0]  weights_in;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [17:0]  out_data;
  logic [3:0]   out_index;
  logic         done;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t        sb_q[$];
  logic [17:0] obs_d[$];
  logic [3:0]  obs_i[$];

  int   first_valid, last_xfer, done_e, stall_seen;
  logic done_busy, post_done, post_busy;
  bit   stall_moved, aborted, timeout;

  conv2x2_mac_engine dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .weights_in(weights_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] model(input logic [127:0] d, input logic [31:0] w, input int n);
    logic [17:0] s;
    int r, c;
    s = 18'd0;
    r = n / 3;
    c = n % 3;
    for (int kr = 0; kr < 2; kr++) begin
      for (int kc = 0; kc < 2; kc++) begin
        s = s + 18'(d[((r + kr) * 4 + c + kc) * 8 +: 8]) * 18'(w[(kr * 2 + kc) * 8 +: 8]);
      end
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] d, input logic [31:0] w);
    data_in    = d;
    weights_in = w;
    start      = 1'b1;
    for (int n = 0; n < 9; n++) begin
      exp_t x;
      x.d = model(d, w, n);
      x.i = 4'(n);
      sb_q.push_back(x);
    end
    step();
    start = 1'b0;
  endtask

  // Runs from just after E0 until done, recording transfers and timing; no checking here.
  task automatic run_until_done(input int budget, input int stall_idx, input int stall_len,
                                input bit poke, input int rst_idx);
    logic        xfer;
    logic [17:0] cd, held_d;
    logic [3:0]  ci, held_i;
    int          stall_left;
    obs_d.delete();
    obs_i.delete();
    first_valid = -1; last_xfer = -1; done_e = -1; stall_seen = 0;
    stall_moved = 1'b0; aborted = 1'b0; timeout = 1'b1;
    done_busy = 1'b1; post_done = 1'b1; post_busy = 1'b1;
    stall_left = stall_len;
    held_d = 18'd0; held_i = 4'd0;
    for (int e = 0; e < budget; e++) begin
      if (out_valid && first_valid < 0) first_valid = e;
      if (done) begin
        start = 1'b0; done_e = e; done_busy = busy; timeout = 1'b0;
        step();
        post_done = done; post_busy = busy;
        break;
      end
      if (rst_idx >= 0 && out_valid && out_index == 4'(rst_idx)) begin
        start = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; aborted = 1'b1; timeout = 1'b0;
        break;
      end
      out_ready = 1'b1;
      if (out_valid && out_index == 4'(stall_idx) && stall_left > 0) begin
        if (stall_left == stall_len) begin
          held_d = out_data; held_i = out_index;
        end else if (out_data != held_d || out_index != held_i) begin
          stall_moved = 1'b1;
        end
        out_ready = 1'b0; stall_left--; stall_seen++;
      end
      if (poke) begin
        if ((e >= 10 && e <= 20) || e == 44) begin
          start = 1'b1;
          data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
          weights_in = $urandom();
        end else begin
          start = 1'b0;
        end
      end
      xfer = out_valid && out_ready;
      cd = out_data;
      ci = out_index;
      step();
      if (xfer) begin
        obs_d.push_back(cd);
        obs_i.push_back(ci);
        last_xfer = e + 1;
      end
    end
    out_ready = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; data_in = '0; weights_in = '0;
    step(); step();
    tests_run++;
    if ({busy, out_valid, done, out_data, out_index} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got busy=%0b valid=%0b done=%0b data=%0d idx=%0d exp all 0",
               busy, out_valid, done, out_data, out_index);
    end
    start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_beats_start got busy=%0b exp 0", busy);
    end
    step();
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_start_no_run got busy=%0b valid=%0b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_ones();
    sb_q.delete();
    do_start({16{8'h01}}, {4{8'h01}});
    run_until_done(80, -1, 0, 1'b0, -1);
    tests_run++;
    if (timeout || first_valid !== 4 || last_xfer !== 45 || done_e !== 45) begin
      tests_failed++;
      $display("FAIL ones_latency got timeout=%0b first_valid=E%0d last_xfer=E%0d done=E%0d exp 0 E4 E45 E45",
               timeout, first_valid, last_xfer, done_e);
    end
    tests_run++;
    if (done_busy !== 1'b0 || post_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ones_done_pulse got busy_at_done=%0b done_next=%0b exp 0 0", done_busy, post_done);
    end
    tests_run++;
    if (obs_d.size() != 9) begin
      tests_failed++;
      $display("FAIL ones_count got %0d exp 9", obs_d.size());
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      exp_t x;
      x = sb_q.pop_front();
      tests_run++;
      if (obs_d[i] !== 18'd4 || obs_d[i] !== x.d || obs_i[i] !== x.i) begin
        tests_failed++;
        $display("FAIL ones_result[%0d] got data=%0d idx=%0d exp data=4 idx=%0d", i, obs_d[i], obs_i[i], x.i);
      end
    end
  endtask

  task automatic test_max();
    sb_q.delete();
    do_start({16{8'hFF}}, {4{8'hFF}});
    run_until_done(80, -1, 0, 1'b0, -1);
    tests_run++;
    if (timeout || obs_d.size() != 9) begin
      tests_failed++;
      $display("FAIL max_count got timeout=%0b count=%0d exp 0 9", timeout, obs_d.size());
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      exp_t x;
      x = sb_q.pop_front();
      tests_run++;
      if (obs_d[i] !== 18'h3F804 || obs_d[i] !== x.d || obs_i[i] !== x.i) begin
        tests_failed++;
        $display("FAIL max_result[%0d] got data=%0h idx=%0d exp data=3f804 idx=%0d", i, obs_d[i], obs_i[i], x.i);
      end
    end
  endtask

  task automatic test_pattern();
    logic [127:0] ramp;
    logic [31:0]  wset[3];
    int           exp_k[3][9];
    wset[0] = 32'h00000001;
    wset[1] = 32'h01000000;
    wset[2] = 32'h04030201;
    exp_k[0] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    exp_k[1] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    exp_k[2] = '{34, -1, -1, -1, -1, -1, -1, -1, -1};
    for (int p = 0; p < 16; p++) ramp[p*8 +: 8] = 8'(p);
    for (int s = 0; s < 3; s++) begin
      sb_q.delete();
      do_start(ramp, wset[s]);
      run_until_done(80, -1, 0, 1'b0, -1);
      tests_run++;
      if (timeout || obs_d.size() != 9) begin
        tests_failed++;
        $display("FAIL pattern%0d_count got timeout=%0b count=%0d exp 0 9", s, timeout, obs_d.size());
      end
      for (int i = 0; i < obs_d.size(); i++) begin
        exp_t x;
        x = sb_q.pop_front();
        tests_run++;
        if (obs_d[i] !== x.d || obs_i[i] !== x.i ||
            (exp_k[s][i] >= 0 && obs_d[i] !== 18'(exp_k[s][i]))) begin
          tests_failed++;
          $display("FAIL pattern%0d_result[%0d] got data=%0d idx=%0d exp data=%0d idx=%0d",
                   s, i, obs_d[i], obs_i[i], x.d, x.i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d;
    sb_q.delete();
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_start(d, $urandom());
    run_until_done(120, 3, 10, 1'b0, -1);
    tests_run++;
    if (stall_seen != 10 || stall_moved) begin
      tests_failed++;
      $display("FAIL bp_hold got stalled_cycles=%0d moved=%0b exp 10 0", stall_seen, stall_moved);
    end
    tests_run++;
    if (timeout || obs_d.size() != 9 || last_xfer !== 55) begin
      tests_failed++;
      $display("FAIL bp_count got timeout=%0b count=%0d last_xfer=E%0d exp 0 9 E55", timeout, obs_d.size(), last_xfer);
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      exp_t x;
      x = sb_q.pop_front();
      tests_run++;
      if (obs_d[i] !== x.d || obs_i[i] !== x.i) begin
        tests_failed++;
        $display("FAIL bp_result[%0d] got data=%0d idx=%0d exp data=%0d idx=%0d", i, obs_d[i], obs_i[i], x.d, x.i);
      end
    end
  endtask

  task automatic test_midrun_start();
    logic [127:0] ramp;
    for (int p = 0; p < 16; p++) ramp[p*8 +: 8] = 8'(p);
    sb_q.delete();
    do_start(ramp, 32'h04030201);
    run_until_done(80, -1, 0, 1'b1, -1);
    tests_run++;
    if (timeout || done_e !== 45 || post_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_no_restart got timeout=%0b done=E%0d busy_after=%0b exp 0 E45 0", timeout, done_e, post_busy);
    end
    tests_run++;
    if (obs_d.size() != 9) begin
      tests_failed++;
      $display("FAIL midrun_count got %0d exp 9", obs_d.size());
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      exp_t x;
      x = sb_q.pop_front();
      tests_run++;
      if (obs_d[i] !== x.d || obs_i[i] !== x.i) begin
        tests_failed++;
        $display("FAIL midrun_result[%0d] got data=%0d idx=%0d exp data=%0d idx=%0d", i, obs_d[i], obs_i[i], x.d, x.i);
      end
    end
  endtask

  task automatic test_rst_midrun();
    sb_q.delete();
    do_start({$urandom(), $urandom(), $urandom(), $urandom()}, $urandom());
    run_until_done(80, -1, 0, 1'b0, 4);
    tests_run++;
    if (!aborted || obs_d.size() != 4) begin
      tests_failed++;
      $display("FAIL rst_mid_reached got aborted=%0b transfers=%0d exp 1 4", aborted, obs_d.size());
    end
    tests_run++;
    if ({busy, out_valid, done, out_data, out_index} !== 25'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs got busy=%0b valid=%0b done=%0b data=%0d idx=%0d exp all 0",
               busy, out_valid, done, out_data, out_index);
    end
    step();
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_idle got busy=%0b valid=%0b exp 0 0", busy, out_valid);
    end
    sb_q.delete();
    do_start({$urandom(), $urandom(), $urandom(), $urandom()}, $urandom());
    run_until_done(80, -1, 0, 1'b0, -1);
    tests_run++;
    if (timeout || obs_d.size() != 9 || first_valid !== 4) begin
      tests_failed++;
      $display("FAIL rst_rerun_count got timeout=%0b count=%0d first_valid=E%0d exp 0 9 E4",
               timeout, obs_d.size(), first_valid);
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      exp_t x;
      x = sb_q.pop_front();
      tests_run++;
      if (obs_d[i] !== x.d || obs_i[i] !== x.i) begin
        tests_failed++;
        $display("FAIL rst_rerun_result[%0d] got data=%0d idx=%0d exp data=%0d idx=%0d", i, obs_d[i], obs_i[i], x.d, x.i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_max();
    test_pattern();
    test_backpressure();
    test_midrun_start();
    test_rst_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
